// File: rtl/stopwatch_counter_if.sv
// Control and display bundle between the stopwatch counter and its driver.
// Handshake: tick is a single-cycle strobe with no ready; the counter never stalls, and a strobe outside RUN is dropped.
interface stopwatch_counter_if;
   logic       tick;
   logic       start_stop;
   logic       clear;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic [3:0] min_tens;
   logic       running;
   logic       rollover;
   logic [1:0] state;

   modport master (
      output tick, start_stop, clear,
      input  sec_ones, sec_tens, min_ones, min_tens, running, rollover, state
   );

   modport slave (
      input  tick, start_stop, clear,
      output sec_ones, sec_tens, min_ones, min_tens, running, rollover, state
   );
endinterface

// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch driven by the one-second tick, with start/stop/clear control.
// The state output is a debug view of the FSM encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3).
module stopwatch_counter #(
   parameter int MAX_MIN = 60,
   parameter int WRAP    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   stopwatch_counter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int         LIM_M  = MAX_MIN - 1;
   localparam logic [3:0] LIM_MT = 4'(LIM_M / 10);
   localparam logic [3:0] LIM_MO = 4'(LIM_M % 10);
   localparam bit         WRAP_B = (WRAP != 0);

   state_t     state_q;
   logic       ss_q;
   logic       ss_edge;
   logic       running_q;
   logic       rollover_q;
   logic [3:0] so_q, st_q, mo_q, mt_q;
   logic [3:0] so_n, st_n, mo_n, mt_n;
   logic       at_limit;

   assign ss_edge  = bus.start_stop & ~ss_q;
   assign at_limit = (mt_q == LIM_MT) && (mo_q == LIM_MO) && (st_q == 4'd5) && (so_q == 4'd9);

   // One-second increment with BCD carries; the limit case is handled in the FSM.
   always_comb begin
      so_n = so_q;
      st_n = st_q;
      mo_n = mo_q;
      mt_n = mt_q;
      if (so_q != 4'd9) begin
         so_n = so_q + 4'd1;
      end else begin
         so_n = 4'd0;
         if (st_q != 4'd5) begin
            st_n = st_q + 4'd1;
         end else begin
            st_n = 4'd0;
            if (mo_q != 4'd9) begin
               mo_n = mo_q + 4'd1;
            end else begin
               mo_n = 4'd0;
               mt_n = mt_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         ss_q       <= 1'b0;
         running_q  <= 1'b0;
         rollover_q <= 1'b0;
         so_q       <= 4'd0;
         st_q       <= 4'd0;
         mo_q       <= 4'd0;
         mt_q       <= 4'd0;
      end else begin
         ss_q       <= bus.start_stop;
         rollover_q <= 1'b0;
         if (bus.clear) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            so_q      <= 4'd0;
            st_q      <= 4'd0;
            mo_q      <= 4'd0;
            mt_q      <= 4'd0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (ss_edge) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                  end
               end
               RUN: begin
                  if (bus.tick) begin
                     if (at_limit) begin
                        rollover_q <= 1'b1;
                        if (WRAP_B) begin
                           so_q <= 4'd0;
                           st_q <= 4'd0;
                           mo_q <= 4'd0;
                           mt_q <= 4'd0;
                        end
                     end else begin
                        so_q <= so_n;
                        st_q <= st_n;
                        mo_q <= mo_n;
                        mt_q <= mt_n;
                     end
                  end
                  // Reaching the hold limit wins over a stop edge in the same cycle.
                  if (bus.tick && at_limit && !WRAP_B) begin
                     state_q   <= DONE;
                     running_q <= 1'b0;
                  end else if (ss_edge) begin
                     state_q   <= PAUSE;
                     running_q <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (ss_edge) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                  end
               end
               default: begin
                  state_q   <= DONE;
                  running_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.sec_ones = so_q;
   assign bus.sec_tens = st_q;
   assign bus.min_ones = mo_q;
   assign bus.min_tens = mt_q;
   assign bus.running  = running_q;
   assign bus.rollover = rollover_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: default 60-minute wrap, 2-minute wrap and 2-minute hold variants.
module tb_stopwatch_counter;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   logic [2:0]       tick_v;
   logic [2:0]       ss_v;
   logic [2:0]       clr_v;
   logic [2:0][15:0] disp;
   logic [2:0]       run_v;
   logic [2:0]       roll_v;
   logic [2:0][1:0]  st_v;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   stopwatch_counter_if if0 ();
   stopwatch_counter_if if1 ();
   stopwatch_counter_if if2 ();

   stopwatch_counter #(.MAX_MIN(60), .WRAP(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   stopwatch_counter #(.MAX_MIN(2),  .WRAP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   stopwatch_counter #(.MAX_MIN(2),  .WRAP(0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

   assign if0.tick = tick_v[0];  assign if0.start_stop = ss_v[0];  assign if0.clear = clr_v[0];
   assign if1.tick = tick_v[1];  assign if1.start_stop = ss_v[1];  assign if1.clear = clr_v[1];
   assign if2.tick = tick_v[2];  assign if2.start_stop = ss_v[2];  assign if2.clear = clr_v[2];

   assign disp[0] = {if0.min_tens, if0.min_ones, if0.sec_tens, if0.sec_ones};
   assign disp[1] = {if1.min_tens, if1.min_ones, if1.sec_tens, if1.sec_ones};
   assign disp[2] = {if2.min_tens, if2.min_ones, if2.sec_tens, if2.sec_ones};
   assign run_v   = {if2.running,  if1.running,  if0.running};
   assign roll_v  = {if2.rollover, if1.rollover, if0.rollover};
   assign st_v[0] = if0.state;
   assign st_v[1] = if1.state;
   assign st_v[2] = if2.state;

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: inputs change on the falling edge, outputs are read on the falling edge.
   task automatic do_ticks(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) tick_v[d] = 1'b1;
         @(negedge clk) tick_v[d] = 1'b0;
      end
   endtask

   task automatic ss_pulse(input int d);
      @(negedge clk) ss_v[d] = 1'b1;
      @(negedge clk) ss_v[d] = 1'b0;
   endtask

   task automatic clr_pulse(input int d);
      @(negedge clk) clr_v[d] = 1'b1;
      @(negedge clk) clr_v[d] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tick_v = 3'($urandom_range(0, 7));
         ss_v   = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (disp[d] !== 16'h0000 || run_v[d] !== 1'b0 || roll_v[d] !== 1'b0 || st_v[d] !== S_IDLE) begin
            fails++;
            $display("FAIL reset_dut%0d: disp=%h run=%b roll=%b state=%0d, want 0000/0/0/0",
                     d, disp[d], run_v[d], roll_v[d], st_v[d]);
         end
      end
      tick_v = '0;
      ss_v   = '0;
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_edge_start();
      @(negedge clk) ss_v[0] = 1'b1;
      @(negedge clk);
      tests++;
      if (run_v[0] !== 1'b1) begin
         fails++;
         $display("FAIL edge_run_1clk: running=%b want 1", run_v[0]);
      end
      repeat (9) @(negedge clk);
      ss_v[0] = 1'b0;
      do_ticks(0, 12);
      tests++;
      if (run_v[0] !== 1'b1 || st_v[0] !== S_RUN) begin
         fails++;
         $display("FAIL edge_single_toggle: running=%b state=%0d want 1/1", run_v[0], st_v[0]);
      end
      tests++;
      if (disp[0] !== 16'h0012) begin
         fails++;
         $display("FAIL edge_disp: got %h want 0012", disp[0]);
      end
   endtask

   task automatic test_seconds_carry();
      clr_pulse(0);
      tests++;
      if (disp[0] !== 16'h0000 || st_v[0] !== S_IDLE) begin
         fails++;
         $display("FAIL carry_clear: disp=%h state=%0d want 0000/0", disp[0], st_v[0]);
      end
      ss_pulse(0);
      do_ticks(0, 60);
      tests++;
      if (disp[0] !== 16'h0100) begin
         fails++;
         $display("FAIL carry_60: got %h want 0100", disp[0]);
      end
      ss_pulse(0);
      do_ticks(0, 5);
      tests++;
      if (disp[0] !== 16'h0100 || run_v[0] !== 1'b0 || st_v[0] !== S_PAUSE) begin
         fails++;
         $display("FAIL carry_pause: disp=%h run=%b state=%0d want 0100/0/2", disp[0], run_v[0], st_v[0]);
      end
      ss_pulse(0);
      do_ticks(0, 1);
      tests++;
      if (disp[0] !== 16'h0101 || run_v[0] !== 1'b1) begin
         fails++;
         $display("FAIL carry_resume: disp=%h run=%b want 0101/1", disp[0], run_v[0]);
      end
   endtask

   task automatic test_wrap();
      ss_pulse(1);
      do_ticks(1, 119);
      tests++;
      if (disp[1] !== 16'h0159 || roll_v[1] !== 1'b0) begin
         fails++;
         $display("FAIL wrap_pre: disp=%h roll=%b want 0159/0", disp[1], roll_v[1]);
      end
      @(negedge clk) tick_v[1] = 1'b1;
      @(negedge clk) tick_v[1] = 1'b0;
      tests++;
      if (disp[1] !== 16'h0000 || roll_v[1] !== 1'b1 || run_v[1] !== 1'b1) begin
         fails++;
         $display("FAIL wrap_limit: disp=%h roll=%b run=%b want 0000/1/1", disp[1], roll_v[1], run_v[1]);
      end
      @(negedge clk);
      tests++;
      if (roll_v[1] !== 1'b0 || run_v[1] !== 1'b1 || st_v[1] !== S_RUN) begin
         fails++;
         $display("FAIL wrap_pulse_len: roll=%b run=%b state=%0d want 0/1/1", roll_v[1], run_v[1], st_v[1]);
      end
      do_ticks(1, 1);
      tests++;
      if (disp[1] !== 16'h0001) begin
         fails++;
         $display("FAIL wrap_continue: got %h want 0001", disp[1]);
      end
   endtask

   task automatic test_done();
      ss_pulse(2);
      do_ticks(2, 119);
      @(negedge clk) tick_v[2] = 1'b1;
      @(negedge clk) tick_v[2] = 1'b0;
      tests++;
      if (disp[2] !== 16'h0159 || roll_v[2] !== 1'b1 || run_v[2] !== 1'b0 || st_v[2] !== S_DONE) begin
         fails++;
         $display("FAIL done_limit: disp=%h roll=%b run=%b state=%0d want 0159/1/0/3",
                  disp[2], roll_v[2], run_v[2], st_v[2]);
      end
      @(negedge clk);
      tests++;
      if (roll_v[2] !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse_len: roll=%b want 0", roll_v[2]);
      end
      ss_pulse(2);
      do_ticks(2, 1);
      tests++;
      if (disp[2] !== 16'h0159 || run_v[2] !== 1'b0 || st_v[2] !== S_DONE || roll_v[2] !== 1'b0) begin
         fails++;
         $display("FAIL done_ignore: disp=%h run=%b state=%0d roll=%b want 0159/0/3/0",
                  disp[2], run_v[2], st_v[2], roll_v[2]);
      end
      clr_pulse(2);
      tests++;
      if (disp[2] !== 16'h0000 || st_v[2] !== S_IDLE) begin
         fails++;
         $display("FAIL done_clear: disp=%h state=%0d want 0000/0", disp[2], st_v[2]);
      end
   endtask

   task automatic test_simultaneous();
      clr_pulse(0);
      @(negedge clk) begin tick_v[0] = 1'b1; ss_v[0] = 1'b1; end
      @(negedge clk) begin tick_v[0] = 1'b0; ss_v[0] = 1'b0; end
      tests++;
      if (disp[0] !== 16'h0000 || run_v[0] !== 1'b1) begin
         fails++;
         $display("FAIL sim_tick_start: disp=%h run=%b want 0000/1", disp[0], run_v[0]);
      end
      do_ticks(0, 2);
      @(negedge clk) begin tick_v[0] = 1'b1; clr_v[0] = 1'b1; end
      @(negedge clk) begin tick_v[0] = 1'b0; clr_v[0] = 1'b0; end
      tests++;
      if (disp[0] !== 16'h0000 || run_v[0] !== 1'b0 || st_v[0] !== S_IDLE) begin
         fails++;
         $display("FAIL sim_tick_clear: disp=%h run=%b state=%0d want 0000/0/0", disp[0], run_v[0], st_v[0]);
      end
      ss_pulse(0);
      do_ticks(0, 9);
      tests++;
      if (disp[0] !== 16'h0009) begin
         fails++;
         $display("FAIL sim_pre_stop: got %h want 0009", disp[0]);
      end
      @(negedge clk) begin tick_v[0] = 1'b1; ss_v[0] = 1'b1; end
      @(negedge clk) begin tick_v[0] = 1'b0; ss_v[0] = 1'b0; end
      tests++;
      if (disp[0] !== 16'h0010 || run_v[0] !== 1'b0 || st_v[0] !== S_PAUSE) begin
         fails++;
         $display("FAIL sim_tick_stop: disp=%h run=%b state=%0d want 0010/0/2", disp[0], run_v[0], st_v[0]);
      end
   endtask

   task automatic test_mid_reset();
      ss_pulse(0);
      do_ticks(0, 3);
      tests++;
      if (disp[0] !== 16'h0013) begin
         fails++;
         $display("FAIL midrst_pre: got %h want 0013", disp[0]);
      end
      @(negedge clk) begin reset = 1'b0; tick_v[0] = 1'b1; ss_v[0] = 1'b1; end
      @(negedge clk) tick_v[0] = 1'b0;
      tests++;
      if (disp[0] !== 16'h0000 || run_v[0] !== 1'b0 || st_v[0] !== S_IDLE) begin
         fails++;
         $display("FAIL midrst_clear: disp=%h run=%b state=%0d want 0000/0/0", disp[0], run_v[0], st_v[0]);
      end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (run_v[0] !== 1'b1 || st_v[0] !== S_RUN) begin
         fails++;
         $display("FAIL midrst_level_edge: run=%b state=%0d want 1/1", run_v[0], st_v[0]);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (run_v[0] !== 1'b1 || st_v[0] !== S_RUN) begin
         fails++;
         $display("FAIL midrst_held_level: run=%b state=%0d want 1/1", run_v[0], st_v[0]);
      end
      ss_v[0] = 1'b0;
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      reset  = 1'b0;
      tick_v = '0;
      ss_v   = '0;
      clr_v  = '0;
      test_reset();
      test_edge_start();
      test_seconds_carry();
      test_wrap();
      test_done();
      test_simultaneous();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
